apb_master_bridge: RTL
======================

// Module: apb_master_bridge
// PURPOSE
// - APB3 initiator: turns a single-outstanding local cmd/rsp handshake into APB transfers (IDLE->SETUP->ACCESS).
// - Sits between a local requester (CPU shim, DMA, bench driver) and one APB slave. One psel only.
// PARAMETERS
// ADDR_WIDTH      32   cmd_addr_i / paddr_o width
// DATA_WIDTH      32   wdata/rdata width
// TIMEOUT_CYCLES  256  max ACCESS cycles before abort (APB_MASTER_TIMEOUT_EN only); legal range >=2
// PORTS
// pclk_i       in   1           APB clock
// prstn_i      in   1           reset, asynchronous, active-low
// cmd_valid_i  in   1           command request
// cmd_ready_o  out  1           command accepted when cmd_valid_i & cmd_ready_o at posedge
// cmd_write_i  in   1           1=write, 0=read
// cmd_addr_i   in   ADDR_WIDTH  transfer address
// cmd_wdata_i  in   DATA_WIDTH  write data
// rsp_valid_o  out  1           one-cycle pulse: transfer complete
// rsp_rdata_o  out  DATA_WIDTH  read data; held until next read completes
// rsp_err_o    out  1           slave error or timeout; qualified by rsp_valid_o
// psel_o       out  1           APB select
// penable_o    out  1           APB enable
// pwrite_o     out  1           APB direction
// paddr_o      out  ADDR_WIDTH  APB address
// pwdata_o     out  DATA_WIDTH  APB write data
// pready_i     in   1           APB ready
// prdata_i     in   DATA_WIDTH  APB read data
// pslverr_i    in   1           APB slave error
// BEHAVIOUR
// - Reset (async): state IDLE; psel/penable/pwrite/paddr/pwdata/rsp_valid/rsp_rdata/rsp_err = 0.
// - cmd_ready_o = (state==IDLE), combinational; high from reset release. No command buffering.
// - IDLE: on accept, register write/addr into pwrite_o/paddr_o; pwdata_o <= cmd_wdata_i on writes only
//   (reads leave pwdata_o unchanged); psel_o<=1, penable_o<=0; -> SETUP.
// - SETUP: exactly one cycle; penable_o<=1; -> ACCESS. pready_i/pslverr_i ignored.
// - ACCESS: paddr/pwrite/pwdata/psel/penable held stable. pready_i=1 at posedge completes:
//   psel_o,penable_o<=0; rsp_valid_o<=1 next cycle; rsp_err_o<=pslverr_i; rsp_rdata_o<=prdata_i on reads
//   only (writes leave it unchanged); -> IDLE.
// - pslverr_i sampled only when psel&penable&pready_i.
// - Latency: zero-wait-state transfer -> rsp_valid_o high 3 cycles after accept edge; +1 per wait state.
// - rsp_valid_o is a 1-cycle pulse, no backpressure; rsp_err_o cleared with it (0 when rsp_valid_o=0).
// - Back-to-back: cmd_ready_o high in rsp_valid_o cycle; new cmd accepted that edge; psel_o low exactly 1 cycle.
// - paddr/pwrite/pwdata keep last values after completion (no return-to-zero).
// - Reset mid-transfer: outputs drop immediately; no rsp issued; IDLE after release.
// CONFIGURATION
// - APB_MASTER_TIMEOUT_EN defined: wait counter, width $clog2(TIMEOUT_CYCLES+1), cleared on SETUP->ACCESS,
//   +1 per ACCESS cycle with pready_i=0. If pready_i low for all of TIMEOUT_CYCLES ACCESS cycles, abort at
//   edge ending the last: psel/penable<=0, rsp_valid=1, rsp_err=1, rsp_rdata unchanged, -> IDLE.
//   pready_i=1 in last cycle is a normal completion, not a timeout.
// - Undefined: ACCESS waits indefinitely; no counter logic synthesized.
// TESTING
// 1. Write 0x1000/0xDEADBEEF, pready_i=1 -> psel +1, penable +2, rsp_valid +3, err=0; paddr/pwdata stable in SETUP+ACCESS.
// 2. Read 0x2004, 3 wait states, prdata=0x12345678 at pready -> rsp_valid +6, rsp_rdata=0x12345678, psel high 5 cycles.
// 3. Read with pready&pslverr=1 -> rsp_err=1 one cycle; next write to 0x0 clean -> rsp_err=0, rsp_rdata unchanged.
// 4. cmd_valid held for 2 cmds (write 0x10, read 0x14) -> 2nd accepted in rsp_valid cycle; psel low exactly 1 cycle.
// 5. prstn_i low mid-ACCESS (pready=0) -> psel/penable/rsp_valid 0 immediately; cmd_ready=1 after release; no rsp.
// 6. TIMEOUT_CYCLES=4, pready_i=0 -> macro on: rsp_valid+err=1 after 4 ACCESS cycles; off: psel stays high 100 cycles.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB3 initiator: one outstanding local cmd/rsp transfer mapped onto IDLE->SETUP->ACCESS.
// Optional ACCESS-phase timeout abort is enabled with `define APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  pclk_i,
  input  logic                  prstn_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  input  logic                  pready_i,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pslverr_i
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_e;

  state_e                state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_hit;

  // True during the last ACCESS cycle the slave is allowed to stall.
  assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  assign cmd_ready_o = (state_q == ST_IDLE);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          pwrite_d  = cmd_write_i;
          paddr_d   = cmd_addr_i;
          if (cmd_write_i) pwdata_d = cmd_wdata_i;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ST_ACCESS: begin
        if (pready_i) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr_i;
          if (!pwrite_q) rsp_rdata_d = prdata_i;
          state_d     = ST_IDLE;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (timeout_hit) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge pclk_i or negedge prstn_i) begin
    if (!prstn_i) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
